// File: rtl/core_ctrl_pkg.sv
// Package for the multi-core boot/run controller.
// Holds the per-core state encoding and the index-width helper, which the
// channel and the top level both use.
package core_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        RUN   = 2'd2,
        HALT  = 2'd3
    } core_state_e;

    // Width needed to index n items; never less than one bit.
    function automatic int idx_w(input int n);
        if (n <= 2) return 1;
        return $clog2(n);
    endfunction

endpackage

// File: rtl/core_ctrl_chan.sv
// One controlled core: boot/run sequencer plus alert monitor.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   accept_i          start handshake accepted for this core this cycle
//   start_addr_i      boot address captured on accept
//   stop_i, clr_i     stop request / clear of counter, flag and HALT
//   alert_minor_i     minor alert level (rising edges are counted)
//   alert_major_i     major alert level (rising edge sets sticky flag)
//   boot_addr_o       captured boot address
//   fetch_enable_o    high in RUN only
//   running_o         state == RUN
//   idle_o            state == IDLE (start may be accepted)
//   minor_cnt_o       saturating minor-edge count
//   cnt_sat_o         minor counter at its maximum
//   major_seen_o      sticky major-alert flag
module core_ctrl_chan
    import core_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int CNT_W       = 8,
    parameter int FETCH_DELAY = 4,
    parameter int MAJOR_HALT  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              accept_i,
    input  logic [ADDR_W-1:0] start_addr_i,
    input  logic              stop_i,
    input  logic              clr_i,
    input  logic              alert_minor_i,
    input  logic              alert_major_i,
    output logic [ADDR_W-1:0] boot_addr_o,
    output logic              fetch_enable_o,
    output logic              running_o,
    output logic              idle_o,
    output logic [CNT_W-1:0]  minor_cnt_o,
    output logic              cnt_sat_o,
    output logic              major_seen_o
);

    localparam int                DLY_W    = idx_w(FETCH_DELAY);
    localparam logic [DLY_W-1:0]  DLY_INIT = DLY_W'(FETCH_DELAY - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    core_state_e      state_q, state_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic             minor_q, major_q;
    logic             minor_edge, major_edge;
    logic             halt_req;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    // A clear in the same cycle swallows the edge; history still tracks the level.
    assign minor_edge = alert_minor_i & ~minor_q & ~clr_i;
    assign major_edge = alert_major_i & ~major_q & ~clr_i;
    assign halt_req   = (MAJOR_HALT != 0) && major_edge;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            dly_q   <= '0;
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
        end
    end

    // Next-state logic; stop wins over a major-alert halt.
    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        case (state_q)
            IDLE: begin
                if (accept_i) begin
                    state_d = SETUP;
                    dly_d   = DLY_INIT;
                end
            end
            SETUP: begin
                if (stop_i)              state_d = IDLE;
                else if (halt_req)       state_d = HALT;
                else if (dly_q == '0)    state_d = RUN;
                else                     dly_d   = dly_q - 1'b1;
            end
            RUN: begin
                if (stop_i)              state_d = IDLE;
                else if (halt_req)       state_d = HALT;
            end
            HALT: begin
                if (clr_i)               state_d = IDLE;
            end
            default:                     state_d = IDLE;
        endcase
    end

    // Outputs decoded from the state; reset drops fetch without waiting for a clock.
    always_comb begin
        fetch_enable_o = (state_q == RUN);
        running_o      = (state_q == RUN);
        idle_o         = (state_q == IDLE);
    end

    // Boot address, edge history, counter and sticky flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            boot_addr_o  <= '0;
            minor_q      <= 1'b0;
            major_q      <= 1'b0;
            minor_cnt_o  <= '0;
            major_seen_o <= 1'b0;
        end else begin
            if (accept_i) boot_addr_o <= start_addr_i;
            minor_q <= alert_minor_i;
            major_q <= alert_major_i;
            if (clr_i) begin
                minor_cnt_o  <= '0;
                major_seen_o <= 1'b0;
            end else begin
                if (minor_edge) minor_cnt_o  <= sat_inc(minor_cnt_o);
                if (major_edge) major_seen_o <= 1'b1;
            end
        end
    end

    assign cnt_sat_o = (minor_cnt_o == CNT_MAX);

endmodule

// File: rtl/core_ctrl_status_mon.sv
// Multi-core boot/run controller and status monitor.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   start_valid_i / start_ready_o / start_core_i / start_addr_i
//                    start handshake targeting one core
//   stop_i, clr_i    per-core stop and clear
//   alert_minor_i, alert_major_i, core_sleep_i   per-core status inputs
//   boot_addr_o      per-core boot address, core k at [k*ADDR_W +: ADDR_W]
//   fetch_enable_o, running_o, major_seen_o      per-core status
//   minor_cnt_o      per-core minor count, core k at [k*CNT_W +: CNT_W]
//   all_asleep_o     registered: >=1 core in RUN and every RUN core asleep
//   irq_o            registered: any major flag or any saturated counter
module core_ctrl_status_mon
    import core_ctrl_pkg::*;
#(
    parameter  int NUM_CORES   = 2,
    parameter  int ADDR_W      = 32,
    parameter  int CNT_W       = 8,
    parameter  int FETCH_DELAY = 4,
    parameter  int MAJOR_HALT  = 1,
    localparam int IDX_W       = idx_w(NUM_CORES)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_valid_i,
    output logic                        start_ready_o,
    input  logic [IDX_W-1:0]            start_core_i,
    input  logic [ADDR_W-1:0]           start_addr_i,
    input  logic [NUM_CORES-1:0]        stop_i,
    input  logic [NUM_CORES-1:0]        clr_i,
    input  logic [NUM_CORES-1:0]        alert_minor_i,
    input  logic [NUM_CORES-1:0]        alert_major_i,
    input  logic [NUM_CORES-1:0]        core_sleep_i,
    output logic [NUM_CORES*ADDR_W-1:0] boot_addr_o,
    output logic [NUM_CORES-1:0]        fetch_enable_o,
    output logic [NUM_CORES-1:0]        running_o,
    output logic [NUM_CORES*CNT_W-1:0]  minor_cnt_o,
    output logic [NUM_CORES-1:0]        major_seen_o,
    output logic                        all_asleep_o,
    output logic                        irq_o
);

    logic [NUM_CORES-1:0] idle;
    logic [NUM_CORES-1:0] sat;
    logic [NUM_CORES-1:0] sel;
    logic [NUM_CORES-1:0] accept;

    // Decode the target; an index past the last core matches nothing, so it is never ready.
    always_comb begin
        start_ready_o = 1'b0;
        sel           = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (start_core_i == IDX_W'(k)) begin
                sel[k]        = 1'b1;
                start_ready_o = idle[k];
            end
        end
    end

    assign accept = sel & {NUM_CORES{start_valid_i & start_ready_o}};

    for (genvar k = 0; k < NUM_CORES; k++) begin : g_chan
        core_ctrl_chan #(
            .ADDR_W      (ADDR_W),
            .CNT_W       (CNT_W),
            .FETCH_DELAY (FETCH_DELAY),
            .MAJOR_HALT  (MAJOR_HALT)
        ) u_chan (
            .clk            (clk),
            .rst            (rst),
            .accept_i       (accept[k]),
            .start_addr_i   (start_addr_i),
            .stop_i         (stop_i[k]),
            .clr_i          (clr_i[k]),
            .alert_minor_i  (alert_minor_i[k]),
            .alert_major_i  (alert_major_i[k]),
            .boot_addr_o    (boot_addr_o[k*ADDR_W +: ADDR_W]),
            .fetch_enable_o (fetch_enable_o[k]),
            .running_o      (running_o[k]),
            .idle_o         (idle[k]),
            .minor_cnt_o    (minor_cnt_o[k*CNT_W +: CNT_W]),
            .cnt_sat_o      (sat[k]),
            .major_seen_o   (major_seen_o[k])
        );
    end

    // Aggregates: cores outside RUN do not block the all-asleep condition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            all_asleep_o <= 1'b0;
            irq_o        <= 1'b0;
        end else begin
            all_asleep_o <= (|running_o) && (&(core_sleep_i | ~running_o));
            irq_o        <= (|major_seen_o) || (|sat);
        end
    end

endmodule

// File: tb/tb_core_ctrl_status_mon.sv
module tb_core_ctrl_status_mon;

    localparam int NC = 3;
    localparam int AW = 32;
    localparam int CW = 3;
    localparam int IW = 2;

    localparam int S_READY = 0, S_BOOT = 1, S_FETCH = 2, S_RUN = 3,
                   S_CNT = 4, S_SEEN = 5, S_ASLEEP = 6, S_IRQ = 7;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_valid_i;
    logic              start_ready_o;
    logic [IW-1:0]     start_core_i;
    logic [AW-1:0]     start_addr_i;
    logic [NC-1:0]     stop_i, clr_i, alert_minor_i, alert_major_i, core_sleep_i;
    logic [NC*AW-1:0]  boot_addr_o;
    logic [NC-1:0]     fetch_enable_o, running_o, major_seen_o;
    logic [NC*CW-1:0]  minor_cnt_o;
    logic              all_asleep_o, irq_o;

    core_ctrl_status_mon #(
        .NUM_CORES   (NC),
        .ADDR_W      (AW),
        .CNT_W       (CW),
        .FETCH_DELAY (4),
        .MAJOR_HALT  (1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start_valid_i  (start_valid_i),
        .start_ready_o  (start_ready_o),
        .start_core_i   (start_core_i),
        .start_addr_i   (start_addr_i),
        .stop_i         (stop_i),
        .clr_i          (clr_i),
        .alert_minor_i  (alert_minor_i),
        .alert_major_i  (alert_major_i),
        .core_sleep_i   (core_sleep_i),
        .boot_addr_o    (boot_addr_o),
        .fetch_enable_o (fetch_enable_o),
        .running_o      (running_o),
        .minor_cnt_o    (minor_cnt_o),
        .major_seen_o   (major_seen_o),
        .all_asleep_o   (all_asleep_o),
        .irq_o          (irq_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          sig;
        int          core;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc++;

    function automatic logic [31:0] actual(input int sig, input int core);
        logic [31:0] v;
        v = '0;
        case (sig)
            S_READY:  v[0]    = start_ready_o;
            S_BOOT:   v       = boot_addr_o[core*AW +: AW];
            S_FETCH:  v[0]    = fetch_enable_o[core];
            S_RUN:    v[0]    = running_o[core];
            S_CNT:    v[CW-1:0] = minor_cnt_o[core*CW +: CW];
            S_SEEN:   v[0]    = major_seen_o[core];
            S_ASLEEP: v[0]    = all_asleep_o;
            S_IRQ:    v[0]    = irq_o;
            default:  v       = '0;
        endcase
        return v;
    endfunction

    // Scoreboard monitor: compares every expectation due in the current cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            logic [31:0] a;
            e = q.pop_front();
            a = actual(e.sig, e.core);
            n_cmp++;
            if (a !== e.exp) begin
                n_bad++;
                $display("FAIL %s core%0d: got 0x%0h, expected 0x%0h (cycle %0d)",
                         e.name, e.core, a, e.exp, cyc);
            end
        end
    end

    task automatic expect_v(input string name, input int sig, input int core, input logic [31:0] v);
        exp_t e;
        e.cyc = cyc; e.sig = sig; e.core = core; e.exp = v; e.name = name;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_core(input logic [IW-1:0] c, input logic [AW-1:0] a);
        start_valid_i = 1'b1; start_core_i = c; start_addr_i = a;
        expect_v("ready_before_accept", S_READY, c, 32'd1);
        step();
        start_valid_i = 1'b0;
    endtask

    task automatic minor_pulse(input int c);
        alert_minor_i[c] = 1'b1; step();
        alert_minor_i[c] = 1'b0; step();
    endtask

    initial begin
        rst = 1'b1;
        start_valid_i = 1'b0; start_core_i = '0; start_addr_i = '0;
        stop_i = '0; clr_i = '0; alert_minor_i = '0; alert_major_i = '0; core_sleep_i = '0;
        step(); step();
        for (int c = 0; c < NC; c++) begin
            expect_v("rst_fetch", S_FETCH, c, 0);
            expect_v("rst_boot",  S_BOOT,  c, 0);
            expect_v("rst_cnt",   S_CNT,   c, 0);
            expect_v("rst_seen",  S_SEEN,  c, 0);
        end
        expect_v("rst_irq", S_IRQ, 0, 0);
        expect_v("rst_asleep", S_ASLEEP, 0, 0);
        rst = 1'b0;
        step();

        // Start core 1: boot address next cycle, fetch after four more edges
        start_core(2'd1, 32'h0000_8000);
        expect_v("boot1", S_BOOT, 1, 32'h8000);
        expect_v("boot0_untouched", S_BOOT, 0, 0);
        start_core_i = 2'd1;
        expect_v("ready_setup", S_READY, 1, 0);
        for (int i = 0; i < 4; i++) begin
            expect_v("fetch1_setup", S_FETCH, 1, 0);
            step();
        end
        expect_v("fetch1_rise", S_FETCH, 1, 1);
        expect_v("run1", S_RUN, 1, 1);
        expect_v("fetch0_idle", S_FETCH, 0, 0);

        // Start core 0
        start_core(2'd0, 32'h0000_0100);
        repeat (4) step();
        expect_v("fetch0_rise", S_FETCH, 0, 1);
        expect_v("boot0", S_BOOT, 0, 32'h100);

        // Sleep aggregation (core 2 idle, ignored)
        core_sleep_i = 3'b011;
        expect_v("asleep_lag", S_ASLEEP, 0, 0);
        step();
        expect_v("asleep_all", S_ASLEEP, 0, 1);
        core_sleep_i = 3'b001;
        step();
        expect_v("asleep_partial", S_ASLEEP, 0, 0);
        core_sleep_i = 3'b000;

        // Minor alerts on core 0: 3 pulses + 5-cycle hold = 4 edges
        for (int i = 0; i < 3; i++) minor_pulse(0);
        alert_minor_i[0] = 1'b1;
        repeat (5) step();
        alert_minor_i[0] = 1'b0;
        step();
        expect_v("cnt0_four", S_CNT, 0, 4);
        expect_v("cnt1_zero", S_CNT, 1, 0);
        expect_v("irq_nosat", S_IRQ, 0, 0);
        for (int i = 0; i < 3; i++) minor_pulse(0);
        expect_v("cnt0_sat", S_CNT, 0, 7);
        expect_v("irq_sat", S_IRQ, 0, 1);
        minor_pulse(0);
        expect_v("cnt0_hold_sat", S_CNT, 0, 7);
        clr_i[0] = 1'b1; step(); clr_i[0] = 1'b0;
        expect_v("cnt0_clr", S_CNT, 0, 0);
        expect_v("fetch0_after_clr", S_FETCH, 0, 1);
        step();
        expect_v("irq_clr", S_IRQ, 0, 0);
        // Clear beats a same-cycle edge, and the held level is not re-counted
        clr_i[0] = 1'b1; alert_minor_i[0] = 1'b1; step();
        clr_i[0] = 1'b0; step();
        expect_v("cnt0_edge_dropped", S_CNT, 0, 0);
        alert_minor_i[0] = 1'b0;

        // Major on core 0 in RUN -> HALT
        alert_major_i[0] = 1'b1; step(); alert_major_i[0] = 1'b0;
        start_core_i = 2'd0;
        expect_v("fetch0_halt", S_FETCH, 0, 0);
        expect_v("seen0", S_SEEN, 0, 1);
        expect_v("ready0_halt", S_READY, 0, 0);
        step();
        expect_v("irq_major", S_IRQ, 0, 1);
        stop_i[0] = 1'b1; step(); stop_i[0] = 1'b0;
        expect_v("ready0_stop_ignored", S_READY, 0, 0);
        clr_i[0] = 1'b1; step(); clr_i[0] = 1'b0;
        expect_v("seen0_clr", S_SEEN, 0, 0);
        expect_v("ready0_idle", S_READY, 0, 1);
        step();
        expect_v("irq_major_clr", S_IRQ, 0, 0);

        // Stop and major edge together on core 1 -> IDLE, flag set
        stop_i[1] = 1'b1; alert_major_i[1] = 1'b1; step();
        stop_i[1] = 1'b0; alert_major_i[1] = 1'b0;
        start_core_i = 2'd1;
        expect_v("fetch1_stop", S_FETCH, 1, 0);
        expect_v("seen1", S_SEEN, 1, 1);
        expect_v("ready1_idle", S_READY, 1, 1);
        clr_i[1] = 1'b1; step(); clr_i[1] = 1'b0;

        // Out-of-range index is never ready or accepted
        start_valid_i = 1'b1; start_core_i = 2'd3; start_addr_i = 32'hDEAD;
        expect_v("ready_oor", S_READY, 3, 0);
        step();
        start_valid_i = 1'b0;
        expect_v("boot0_oor", S_BOOT, 0, 32'h100);
        expect_v("boot1_oor", S_BOOT, 1, 32'h8000);
        expect_v("boot2_oor", S_BOOT, 2, 0);
        expect_v("fetch2_oor", S_FETCH, 2, 0);

        // Reset during SETUP with a running core
        start_core(2'd0, 32'h0000_0300);
        repeat (4) step();
        expect_v("fetch0_rerun", S_FETCH, 0, 1);
        start_core(2'd2, 32'h0000_2000);
        start_core_i = 2'd2;
        expect_v("ready2_setup", S_READY, 2, 0);
        expect_v("boot2", S_BOOT, 2, 32'h2000);
        step();
        rst = 1'b1; alert_minor_i[2] = 1'b1;
        #1;
        expect_v("fetch0_async_rst", S_FETCH, 0, 0);
        expect_v("run0_async_rst", S_RUN, 0, 0);
        expect_v("boot2_rst", S_BOOT, 2, 0);
        expect_v("ready2_rst", S_READY, 2, 1);
        step(); step();
        rst = 1'b0;
        expect_v("cnt2_in_rst", S_CNT, 2, 0);
        step();
        expect_v("cnt2_held_edge", S_CNT, 2, 1);
        step();
        expect_v("cnt2_no_recount", S_CNT, 2, 1);
        alert_minor_i[2] = 1'b0;

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
